// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions used by the load/store unit:
//   - funct3 size/sign encodings for loads and stores
//   - data-path and strobe widths
//   - LSU state enumeration
//   - lsu_misaligned(): alignment / reserved-encoding check used when the
//     LSU_MISALIGN_TRAP_EN build option is enabled
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    // 1 when the access cannot be issued: halfword on an odd address, word
    // not on a word boundary, or one of the reserved size encodings.
    function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                            input logic [1:0] off);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane formatting for the load/store unit.
//   Load side : ld_funct3 / ld_off select a byte, halfword or word lane of
//               ld_word and sign- or zero-extend it onto ld_data.
//   Store side: st_size (funct3[1:0]) / st_off replicate st_data across all
//               lanes onto st_word and build the matching byte strobe st_strb.
// Size encoding is funct3[1:0]: 00 byte, 01 half, 1x word (reserved codes
// therefore fall into the word case).
// -----------------------------------------------------------------------------
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    input  logic [XLEN-1:0]   ld_word,
    output logic [XLEN-1:0]   ld_data,
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_off,
    input  logic [XLEN-1:0]   st_data,
    output logic [XLEN-1:0]   st_word,
    output logic [STRB_W-1:0] st_strb
);

    logic [7:0]  ld_lane [STRB_W];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sext;

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        assign ld_lane[gi] = ld_word[8*gi +: 8];
    end

    always_comb begin
        ld_byte = ld_lane[ld_off];
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        // funct3[2] marks the unsigned variants (LBU/LHU)
        ld_sext = ~ld_funct3[2];
        case (ld_funct3[1:0])
            2'b00:   ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        case (st_size)
            2'b00: begin
                st_word = {4{st_data[7:0]}};
                st_strb = 4'b0001 << st_off;
            end
            2'b01: begin
                st_word = {2{st_data[15:0]}};
                st_strb = st_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_word = st_data;
                st_strb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I data-memory stage. Turns a load/store request from execute into a
// registered req/ack bus transaction, formats load data for writeback and
// stalls the core while the access is outstanding.
//
// Parameters
//   TIMEOUT   bus-wait cycles (2..255) before an access is abandoned, fault=1
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses and
//                         reserved funct3 codes complete immediately with
//                         fault=1 and never reach the bus.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req, we, funct3,    access request from execute (held while stall=1)
//   addr, wdata
//   stall               combinational pipeline hold
//   rdata, fault        registered load result / fault flag (valid in DONE)
//   bus_req, bus_we,    registered bus request, word address, strobes and
//   bus_addr, bus_wstrb,  lane-replicated store data
//   bus_wdata
//   bus_ack, bus_rdata  one-cycle completion pulse and read data from memory
// -----------------------------------------------------------------------------
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic [XLEN-1:0]   rdata,
    output logic              fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
);

    lsu_state_t        state_reg;
    logic [7:0]        count_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        off_reg;

    logic [XLEN-1:0]   ld_data;
    logic [XLEN-1:0]   st_word;
    logic [STRB_W-1:0] st_strb;
    logic              start_fault;

    // Loads are formatted from the request captured at issue time, since
    // bus_addr itself has its low two bits forced to zero.
    lsu_align u_align (
        .ld_funct3 (funct3_reg),
        .ld_off    (off_reg),
        .ld_word   (bus_rdata),
        .ld_data   (ld_data),
        .st_size   (funct3[1:0]),
        .st_off    (addr[1:0]),
        .st_data   (wdata),
        .st_word   (st_word),
        .st_strb   (st_strb)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign start_fault = lsu_misaligned(funct3, addr[1:0]);
`else
    assign start_fault = 1'b0;
`endif

    // DONE is the one cycle the core is allowed to retire the instruction.
    assign stall = req & (state_reg != LSU_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= LSU_IDLE;
            count_reg  <= '0;
            funct3_reg <= '0;
            off_reg    <= '0;
            rdata      <= '0;
            fault      <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
        end else begin
            case (state_reg)
                LSU_IDLE: begin
                    fault <= 1'b0;
                    if (req) begin
                        if (start_fault) begin
                            fault     <= 1'b1;
                            state_reg <= LSU_DONE;
                        end else begin
                            bus_req    <= 1'b1;
                            bus_we     <= we;
                            bus_addr   <= {addr[XLEN-1:2], 2'b00};
                            bus_wstrb  <= we ? st_strb : '0;
                            bus_wdata  <= we ? st_word : '0;
                            funct3_reg <= funct3;
                            off_reg    <= addr[1:0];
                            count_reg  <= '0;
                            state_reg  <= LSU_BUSY;
                        end
                    end
                end

                LSU_BUSY: begin
                    // An ack on the last allowed cycle still wins over timeout.
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        fault     <= 1'b0;
                        state_reg <= LSU_DONE;
                        if (!bus_we) begin
                            rdata <= ld_data;
                        end
                    end else if (count_reg == 8'(TIMEOUT - 1)) begin
                        // count_reg is the number of BUSY cycles already
                        // spent, so bus_req stays high exactly TIMEOUT cycles.
                        bus_req   <= 1'b0;
                        fault     <= 1'b1;
                        state_reg <= LSU_DONE;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end

                LSU_DONE: begin
                    fault     <= 1'b0;
                    state_reg <= LSU_IDLE;
                end

                default: begin
                    state_reg <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Transaction-level reference: each access is described by its operands, the
// memory's wait count and the read word; the expected per-cycle outputs follow
// from the access timeline (issue cycle, bus cycles, DONE cycle, idle gap).
// A single negedge process compares the DUT against those expectations, and
// directed accesses pin literal values from the access rules.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TIMEOUT = 16;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        fault, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .fault     (fault),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    // ---------------- per-cycle expectations ----------------
    bit          chk_en  = 1'b0;
    bit          chk_bus = 1'b0;
    logic        exp_stall, exp_breq, exp_fault, exp_we;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    logic [31:0] model_rdata = 32'h0;

    // values observed during the most recent access, for literal checks
    logic [31:0] got_rdata, got_addr, got_wdata;
    logic [3:0]  got_strb;
    logic        got_fault;
    int          got_stall_cycles, got_breq_cycles;
    bit          got_first;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",   32'(stall),   32'(exp_stall));
            chk("bus_req", 32'(bus_req), 32'(exp_breq));
            chk("fault",   32'(fault),   32'(exp_fault));
            chk("rdata",   rdata,        exp_rdata);
            if (chk_bus) begin
                chk("bus_we",    32'(bus_we),    32'(exp_we));
                chk("bus_addr",  bus_addr,       exp_addr);
                chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_strb));
                if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
            end
        end
    end

    // ---------------- reference rules ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        int s;
        s = size_of(f3);
        if (s == 4) return w;
        if (s == 1) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_swdata(input logic [2:0] f3, input logic [31:0] d);
        int s;
        s = size_of(f3);
        if (s == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (s == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        int s;
        s = size_of(f3);
        if (s == 1) return 4'(1 << a[1:0]);
        if (s == 2) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (size_of(f3) == 2) return a[0];
        if (size_of(f3) == 4) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // ---------------- stimulus ----------------
    task automatic sample(input bit is_done);
        @(negedge clk);
        if (stall === 1'b1) got_stall_cycles++;
        if (bus_req === 1'b1) begin
            got_breq_cycles++;
            if (!got_first) begin
                got_first = 1'b1;
                got_addr  = bus_addr;
                got_strb  = bus_wstrb;
                got_wdata = bus_wdata;
            end
        end
        if (is_done) begin
            got_rdata = rdata;
            got_fault = fault;
        end
        @(posedge clk);
        #1;
    endtask

    // waits >= TIMEOUT means memory never acknowledges
    task automatic do_txn(input logic t_we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int waits,
                          input int gap);
        bit acked, trap;
        int n;
        acked = (waits < TIMEOUT);
        n     = acked ? waits + 1 : TIMEOUT;
        trap  = TRAP_EN && ref_misaligned(f3, a);
        got_stall_cycles = 0;
        got_breq_cycles  = 0;
        got_first        = 1'b0;
        got_addr = '0; got_strb = '0; got_wdata = '0;

        // issue cycle: FSM idle, stray ack must be ignored
        req = 1'b1; we = t_we; funct3 = f3; addr = a; wdata = wd;
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        exp_stall = 1'b1; exp_breq = 1'b0; exp_fault = 1'b0; exp_rdata = model_rdata;
        chk_bus = 1'b0;
        sample(1'b0);

        if (!trap) begin
            for (int k = 1; k <= n; k++) begin
                bus_ack   = acked && (k == n);
                bus_rdata = (k == n) ? rw : $urandom;
                exp_stall = 1'b1; exp_breq = 1'b1;
                exp_we    = t_we;
                exp_addr  = a & 32'hFFFF_FFFC;
                exp_strb  = t_we ? ref_strb(f3, a) : 4'h0;
                exp_wdata = ref_swdata(f3, wd);
                chk_bus   = 1'b1;
                sample(1'b0);
            end
        end

        // DONE cycle: req still held, stall released
        chk_bus = 1'b0;
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        if (!trap && acked && !t_we) model_rdata = ref_load(f3, a, rw);
        exp_stall = 1'b0; exp_breq = 1'b0; exp_fault = trap || !acked; exp_rdata = model_rdata;
        sample(1'b1);

        exp_fault = 1'b0;
        for (int g = 0; g < gap; g++) begin
            req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
            funct3 = 3'($urandom);
            bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
            sample(1'b0);
        end
    endtask

    task automatic reset_mid_busy();
        got_stall_cycles = 0; got_breq_cycles = 0; got_first = 1'b0;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h300; wdata = 32'h0;
        bus_ack = 1'b0;
        exp_stall = 1'b1; exp_breq = 1'b0; exp_fault = 1'b0; exp_rdata = model_rdata;
        chk_bus = 1'b0;
        sample(1'b0);
        exp_breq = 1'b1; chk_bus = 1'b1; exp_we = 1'b0; exp_addr = 32'h300; exp_strb = 4'h0;
        sample(1'b0);
        sample(1'b0);
        // mid-BUSY: asynchronous reset must clear outputs without waiting for a clock
        chk_en = 1'b0; chk_bus = 1'b0;
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_stall",   32'(stall),   32'h0);
        chk("rst_fault",   32'(fault),   32'h0);
        chk("rst_rdata",   rdata,        32'h0);
        chk("rst_wstrb",   32'(bus_wstrb), 32'h0);
        model_rdata = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_stall = 1'b0; exp_breq = 1'b0; exp_fault = 1'b0; exp_rdata = model_rdata;
        chk_en = 1'b1;
        sample(1'b0);
    endtask

    initial begin
        logic t_we;
        logic [2:0] f3;
        int waits;

        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall",   32'(stall),   32'h0);
        chk("reset_bus_req", 32'(bus_req), 32'h0);
        chk("reset_fault",   32'(fault),   32'h0);
        chk("reset_rdata",   rdata,        32'h0);
        chk("reset_bus_addr", bus_addr,    32'h0);
        rst = 1'b0;
        exp_stall = 1'b0; exp_breq = 1'b0; exp_fault = 1'b0; exp_rdata = 32'h0;
        chk_en = 1'b1;
        sample(1'b0);

        // SW 0x100
        do_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1);
        chk("sw_addr",   got_addr,  32'h100);
        chk("sw_strb",   32'(got_strb), 32'hF);
        chk("sw_wdata",  got_wdata, 32'hDEAD_BEEF);
        chk("sw_stall_cycles", 32'(got_stall_cycles), 32'd2);
        chk("sw_fault",  32'(got_fault), 32'h0);

        // LB / LBU 0x103
        do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        chk("lb_rdata",  got_rdata, 32'hFFFF_FF80);
        do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 1);
        chk("lbu_rdata", got_rdata, 32'h0000_0080);

        // SH 0x202
        do_txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0, 1);
        chk("sh_strb",  32'(got_strb), 32'hC);
        chk("sh_wdata", got_wdata, 32'hABCD_ABCD);
        chk("sh_addr",  got_addr,  32'h200);

        // LW with no ack -> timeout
        do_txn(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, TIMEOUT, 2);
        chk("to_breq_cycles",  32'(got_breq_cycles),  32'd16);
        chk("to_stall_cycles", 32'(got_stall_cycles), 32'd17);
        chk("to_fault",        32'(got_fault),        32'h1);

        // LW 0x101: trapped or word access depending on build
        do_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0, 1);
        if (TRAP_EN) begin
            chk("mis_breq_cycles", 32'(got_breq_cycles), 32'd0);
            chk("mis_fault",       32'(got_fault),       32'h1);
        end else begin
            chk("mis_addr",  got_addr,  32'h100);
            chk("mis_rdata", got_rdata, 32'h1122_3344);
            chk("mis_fault", 32'(got_fault), 32'h0);
        end

        // load leaves a nonzero rdata before the reset test
        do_txn(1'b0, 3'b101, 32'h2, 32'h0, 32'hBEEF_0000, 0, 1);
        chk("lhu_rdata", got_rdata, 32'h0000_BEEF);

        reset_mid_busy();
        do_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 2, 1);
        chk("post_rst_rdata",  got_rdata, 32'hCAFE_F00D);
        chk("post_rst_stall",  32'(got_stall_cycles), 32'd4);

        // randomized accesses
        for (int i = 0; i < 200; i++) begin
            t_we = 1'($urandom);
            f3   = t_we ? 3'($urandom_range(0, 2)) : 3'($urandom);
            waits = ($urandom_range(0, 15) == 0) ? TIMEOUT : $urandom_range(0, 3);
            do_txn(t_we, f3, $urandom, $urandom, $urandom, waits, $urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the RV32I core, placed between the execute datapath and the data bus. It converts load/store requests into a registered request/acknowledge bus transaction and produces byte-lane strobes. It returns sign- or zero-extended load data to the memory input of the writeback 4:1 result select. It stalls the core while a transaction is outstanding and flags faulted accesses.

## Interface
Parameters:
- TIMEOUT, 16: bus-wait cycles before an access is abandoned as faulted; range 2..255.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  memory instruction in execute; held by core while stall=1.
- we  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I size/sign field.
- addr  input  32  byte address.
- wdata  input  32  store data (rs2), low bits significant.
- stall  output  1  holds PC/pipeline; combinational.
- rdata  output  32  formatted load data to writeback select; registered.
- fault  output  1  access faulted (misaligned or timeout); valid while in DONE.
- bus_req, bus_we  output  1  bus request / write; registered.
- bus_addr  output  32  word address, addr[1:0] forced to 00; registered.
- bus_wstrb  output  4  byte-lane enables; registered; 0000 on loads.
- bus_wdata  output  32  lane-replicated store data; registered.
- bus_ack  input  1  one-cycle completion pulse from memory.
- bus_rdata  input  32  read word, valid with bus_ack.

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE, all outputs 0, timeout counter 0.
- IDLE, req=1, no fault: latch bus_* from inputs, bus_req=1, counter cleared, go BUSY.
- BUSY: bus_* held stable; counter increments each cycle. On bus_ack: load -> rdata formatted from bus_rdata, fault=0; store -> rdata unchanged; bus_req=0; go DONE. Counter reaching TIMEOUT with no ack: bus_req=0, fault=1, go DONE.
- DONE: one cycle, stall=0, core retires the instruction; go IDLE unconditionally.
- stall = req & (state != DONE). req=0 -> stall=0.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0] (LH/LHU use addr[1]); LW passes through.
- Stores: SB replicates wdata[7:0] to all lanes, strobe 0001<<addr[1:0]; SH replicates wdata[15:0], strobe 0011 or 1100 by addr[1]; SW strobe 1111.
- bus_ack outside BUSY is ignored.
- Reset mid-transaction: state, bus_req and all outputs clear immediately; no completion reported.

## Timing
- Minimum access: req seen cycle 0 (stall=1), bus_req high cycle 1, bus_ack cycle 1 -> DONE cycle 2 (stall=0, rdata valid). 3 cycles per access at zero-wait memory.
- Each extra bus wait cycle adds one stall cycle.
- Timeout: bus_req high exactly TIMEOUT cycles, then DONE with fault=1.
- Back-to-back accesses: DONE -> IDLE always, so a new req starts one cycle after DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1, word with addr[1:0]!=00, or reserved funct3 (011, 110, 111) -> IDLE goes directly to DONE with fault=1, no bus transaction, bus_req stays 0; stall high for one cycle (cycle 0), low in DONE.
- Undefined: no alignment check; halfword uses addr[1], word ignores addr[1:0]; reserved funct3 treated as word access; fault only from timeout.

## Structure
- Shared package rv32i_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), LSU state enum, strobe widths.
- Sub-module lsu_align (combinational): load lane extract/extend and store replicate/strobe generation.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, ack on first BUSY cycle -> bus_addr=0x100, bus_wstrb=1111, bus_wdata=0xDEADBEEF, stall high 2 cycles, fault=0.
- LB addr=0x103, bus_rdata=0x80FF_0000 -> rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr=0x202, wdata=0x1234ABCD -> bus_wstrb=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
- LW with no ack, TIMEOUT=16 -> bus_req high 16 cycles, then fault=1 for one cycle, stall low, FSM returns to IDLE.
- Macro on: LW addr=0x101 -> bus_req never asserted, fault=1 next cycle; macro off: bus_addr=0x100, normal load.
- rst asserted while BUSY -> bus_req, stall, fault, rdata 0 immediately; following req completes normally.
